// File: rtl/fetch_pkg.sv
// Fetch stage shared types and default constants.
// Imported by the fetch_unit top and the pc_incr adder.
package fetch_pkg;

  localparam int DEF_ADDR_W   = 16;
  localparam int DEF_INSTR_W  = 16;
  localparam int DEF_PC_INC   = 2;
  localparam int DEF_RESET_PC = 0;

  typedef enum logic {
    ISSUE = 1'b0,
    WAIT  = 1'b1
  } state_t;

endpackage

// File: rtl/pc_incr.sv
// PC incrementer: W-bit sum of a + INC with carry-out.
// Shared by the pc update and the if_next_pc capture.
module pc_incr
  import fetch_pkg::*;
#(
  parameter int W   = DEF_ADDR_W,
  parameter int INC = DEF_PC_INC
) (
  input  logic [W-1:0] a,
  output logic [W-1:0] sum,
  output logic         carry
);

  logic [W:0] full;

  assign full  = {1'b0, a} + (W+1)'(INC);
  assign sum   = full[W-1:0];
  assign carry = full[W];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC owner, single-outstanding imem
// requests, decode buffer, redirect squash, halt, sticky err.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int INSTR_W  = DEF_INSTR_W,
  parameter int PC_INC   = DEF_PC_INC,
  parameter int RESET_PC = DEF_RESET_PC
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt,
  input  logic               id_stall,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [ADDR_W-1:0]  if_next_pc,
  output logic               halted,
  output logic               err
);

  state_t state_q;
  state_t state_d;

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_sum;
  logic              pc_carry;
  logic              squash_q;
  logic              consume;
  logic              load;

  pc_incr #(
    .W   (ADDR_W),
    .INC (PC_INC)
  ) u_pc_incr (
    .a     (pc_q),
    .sum   (pc_sum),
    .carry (pc_carry)
  );

  assign consume   = if_valid & ~id_stall;
  assign imem_addr = pc_q;
  assign halted    = halt & (state_q == ISSUE);

  // Ack that delivers a live instruction into the buffer.
  assign load = (state_q == WAIT) & imem_ack
              & ~squash_q & ~redirect_valid;

  // Next state and the issue pulse.
  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    unique case (state_q)
      ISSUE: begin
        imem_req = rst & ~halt & ~redirect_valid
                 & (~if_valid | consume);
        if (imem_req) state_d = WAIT;
      end
      WAIT: begin
        if (imem_ack) state_d = ISSUE;
      end
      default: state_d = ISSUE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ISSUE;
    else      state_q <= state_d;
  end

  // PC, squash flag and sticky overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= ADDR_W'(RESET_PC);
      squash_q <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (redirect_valid) pc_q <= redirect_pc;
      else if (load)      pc_q <= pc_sum;
      if (load & pc_carry) err <= 1'b1;
      if (state_q == WAIT) begin
        if (imem_ack)            squash_q <= 1'b0;
        else if (redirect_valid) squash_q <= 1'b1;
      end
    end
  end

  // Decode-facing buffer: fill on live ack, drop on consume/redirect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_valid   <= 1'b0;
      if_instr   <= '0;
      if_pc      <= '0;
      if_next_pc <= '0;
    end else if (load) begin
      if_valid   <= 1'b1;
      if_instr   <= imem_rdata;
      if_pc      <= pc_q;
      if_next_pc <= pc_sum;
    end else if (redirect_valid | consume) begin
      if_valid   <= 1'b0;
    end
  end

endmodule
